// File: rtl/jpeg_idct_tpose_pkg.sv
// Shared constants, FSM state type and read-address transposition for the
// IDCT transpose RAM sequencer.
package jpeg_idct_tpose_pkg;

  localparam int unsigned TPOSE_ADDR_W = 5;
  localparam int unsigned BLOCK_WORDS  = 2 ** TPOSE_ADDR_W;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Read index k -> RAM address (k%8)*4 + k/8, i.e. column-pair-major order.
  function automatic logic [TPOSE_ADDR_W-1:0] tpose_addr(input logic [TPOSE_ADDR_W-1:0] k);
    return {k[2:0], k[4:3]};
  endfunction

endpackage

// File: rtl/jpeg_idct_tpose_buf.sv
// Two-entry valid/ready output FIFO carrying a last tag; head entry drives
// the outputs directly so data is stable while stalled.
module jpeg_idct_tpose_buf #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_push_last,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  input  logic              i_ready,
  output logic [1:0]        o_occ
);

  logic [DATA_W-1:0] r_data [2];
  logic [1:0]        r_last;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_occ;
  logic              w_pop;

  assign o_valid = (r_occ != 2'd0);
  assign w_pop   = o_valid & i_ready;
  assign o_data  = r_data[r_rd_ptr];
  assign o_last  = r_last[r_rd_ptr];
  assign o_occ   = r_occ;

  // Storage, pointers and occupancy; push and pop may coincide.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_last    <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_occ     <= 2'd0;
    end else begin
      if (i_push) begin
        r_data[r_wr_ptr] <= i_push_data;
        r_last[r_wr_ptr] <= i_push_last;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_occ <= r_occ + 2'(i_push) - 2'(w_pop);
    end
  end

endmodule

// File: rtl/jpeg_idct_transpose_ctrl.sv
// Transpose RAM sequencer between the IDCT row and column passes: fills the
// RAM linearly, then reads it back column-pair-major through a 2-entry buffer.
// Optional: define JPEG_IDCT_TPOSE_OVERLAP_EN to let the next block fill the
// addresses already read while the current block drains.
module jpeg_idct_transpose_ctrl
  import jpeg_idct_tpose_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = TPOSE_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  input  logic              out_ready_i,
  output logic              ram_wr0_o,
  output logic [ADDR_W-1:0] ram_addr0_o,
  output logic [DATA_W-1:0] ram_data0_o,
  output logic [ADDR_W-1:0] ram_addr1_o,
  input  logic [DATA_W-1:0] ram_data1_i,
  output logic              busy_o,
  output logic              block_done_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BLOCK_WORDS - 1);

  state_e            r_state;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic [ADDR_W:0]   r_rd_cnt;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              r_in_ready;

  logic              w_wr;
  logic              w_wr_last;
  logic              w_pop;
  logic              w_done;
  logic              w_issue;
  logic              w_room;
  logic [1:0]        w_occ;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_stay;
  logic              w_drain_rdy;

  assign w_wr      = in_valid_i & r_in_ready;
  assign w_wr_last = w_wr & (r_wr_cnt == LAST_ADDR);
  assign w_pop     = out_valid_o & out_ready_i;
  assign w_done    = w_pop & out_last_o;
  // Words held plus word in flight, net of this cycle's pop, must stay below 2.
  assign w_room    = ({1'b0, w_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
  assign w_issue   = (r_state == DRAIN) & ~r_rd_cnt[ADDR_W] & w_room;
  assign w_rd_addr = tpose_addr(r_rd_cnt[ADDR_W-1:0]);

  assign in_ready_o   = r_in_ready;
  assign ram_wr0_o    = w_wr;
  assign ram_addr0_o  = r_wr_cnt;
  assign ram_data0_o  = w_wr ? in_data_i : '0;
  assign ram_addr1_o  = w_issue ? w_rd_addr : r_rd_addr;
  assign busy_o       = (r_state == DRAIN) | (w_occ != 2'd0);
  assign block_done_o = w_done;

`ifdef JPEG_IDCT_TPOSE_OVERLAP_EN
  logic [BLOCK_WORDS-1:0] r_mask;
  logic [BLOCK_WORDS-1:0] w_mask_nxt;
  logic                   r_pending_full;
  logic                   w_pend_nxt;
  logic [ADDR_W-1:0]      w_wr_cnt_nxt;

  // Read-done mask and pending-block flag for the next cycle.
  always_comb begin
    w_mask_nxt   = r_mask;
    w_pend_nxt   = r_pending_full;
    w_wr_cnt_nxt = r_wr_cnt + ADDR_W'(w_wr);
    if (w_issue) begin
      w_mask_nxt[w_rd_addr] = 1'b1;
    end
    if (w_done) begin
      w_mask_nxt = '0;
      w_pend_nxt = 1'b0;
    end else if (w_wr_last && (r_state == DRAIN)) begin
      w_pend_nxt = 1'b1;
    end
  end

  // A full next block, even one completing this cycle, keeps us in DRAIN.
  assign w_stay      = r_pending_full | (w_wr_last & (r_state == DRAIN));
  assign w_drain_rdy = w_mask_nxt[w_wr_cnt_nxt] & ~w_pend_nxt;

  // Mask and pending flag registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mask         <= '0;
      r_pending_full <= 1'b0;
    end else begin
      r_mask         <= w_mask_nxt;
      r_pending_full <= w_pend_nxt;
    end
  end
`else
  assign w_stay      = 1'b0;
  assign w_drain_rdy = 1'b0;
`endif

  // Output buffer between RAM read data and the column pass.
  jpeg_idct_tpose_buf #(
    .DATA_W(DATA_W)
  ) u_buf (
    .i_clk      (clk_i),
    .i_rst_n    (rst_i),
    .i_push     (r_inflight),
    .i_push_data(ram_data1_i),
    .i_push_last(r_inflight_last),
    .o_valid    (out_valid_o),
    .o_data     (out_data_o),
    .o_last     (out_last_o),
    .i_ready    (out_ready_i),
    .o_occ      (w_occ)
  );

  // FSM, counters, read tracking and registered in_ready.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state         <= FILL;
      r_wr_cnt        <= '0;
      r_rd_cnt        <= '0;
      r_rd_addr       <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_in_ready      <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue & (r_rd_cnt[ADDR_W-1:0] == LAST_ADDR);
      if (w_wr) begin
        r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
      end
      if (w_issue) begin
        r_rd_addr <= w_rd_addr;
      end
      if (w_done) begin
        r_rd_cnt <= '0;
      end else if (w_issue) begin
        r_rd_cnt <= r_rd_cnt + (ADDR_W + 1)'(1);
      end
      case (r_state)
        FILL: begin
          if (w_wr_last) begin
            r_state    <= DRAIN;
            r_in_ready <= 1'b0;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        DRAIN: begin
          if (w_done && !w_stay) begin
            r_state    <= FILL;
            r_in_ready <= 1'b1;
          end else begin
            r_in_ready <= w_drain_rdy;
          end
        end
        default: begin
          r_state    <= FILL;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg_idct_transpose_ctrl.sv
// Self-checking bench for jpeg_idct_transpose_ctrl with a behavioural RAM and
// a scoreboard of expected transposed words.
module tb_jpeg_idct_transpose_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic [31:0] in_data_i;
  logic        in_ready_o;
  logic        out_valid_o;
  logic [31:0] out_data_o;
  logic        out_last_o;
  logic        out_ready_i;
  logic        ram_wr0_o;
  logic [4:0]  ram_addr0_o;
  logic [31:0] ram_data0_o;
  logic [4:0]  ram_addr1_o;
  logic [31:0] ram_data1_i = '0;
  logic        busy_o;
  logic        block_done_o;

  always #5 clk_i = ~clk_i;

  jpeg_idct_transpose_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .out_ready_i (out_ready_i),
    .ram_wr0_o   (ram_wr0_o),
    .ram_addr0_o (ram_addr0_o),
    .ram_data0_o (ram_data0_o),
    .ram_addr1_o (ram_addr1_o),
    .ram_data1_i (ram_data1_i),
    .busy_o      (busy_o),
    .block_done_o(block_done_o)
  );

  // Behavioural 32x32 RAM with a registered read port.
  logic [31:0] mem [32];
  always @(posedge clk_i) begin
    if (ram_wr0_o) mem[ram_addr0_o] <= ram_data0_o;
    ram_data1_i <= mem[ram_addr1_o];
  end

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  bit          got_last_q[$];
  int          got_cyc_q[$];
  int          acc_cyc_q[$];
  int          done_cyc_q[$];
  int          stall_err;
  int          occ_err;
  bit          drv_timeout;
  bit          cap_timeout;

  task automatic clear_sb();
    exp_q.delete(); got_q.delete(); got_last_q.delete(); got_cyc_q.delete();
    acc_cyc_q.delete(); done_cyc_q.delete();
    stall_err = 0; occ_err = 0; drv_timeout = 1'b0; cap_timeout = 1'b0;
  endtask

  // Drive n row-major words base, base+1, ...; push each block's transposed order.
  task automatic drive_words(input logic [31:0] base, input int n);
    int i = 0;
    int t = 0;
    while (i < n && t < 2000) begin
      in_valid_i = 1'b1;
      in_data_i  = base + 32'(i);
      @(negedge clk_i);
      if (in_ready_o) begin
        acc_cyc_q.push_back(cyc);
        i++;
        if (i % 32 == 0)
          for (int k = 0; k < 32; k++)
            exp_q.push_back(base + 32'(i - 32) + 32'((k % 8) * 4 + k / 8));
      end
      @(posedge clk_i); #1; t++;
    end
    in_valid_i = 1'b0;
    if (i < n) drv_timeout = 1'b1;
  endtask

  // Collect n popped outputs, watching stall stability and buffer occupancy.
  task automatic capture(input int n, input bit rand_rdy, input int max_cyc);
    int          t = 0;
    bit          stalled = 1'b0;
    logic [31:0] held = '0;
    while (got_q.size() < n && t < max_cyc) begin
      out_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk_i);
      if (stalled && (out_valid_o !== 1'b1 || out_data_o !== held)) stall_err++;
      if (dut.w_occ > 2'd2) occ_err++;
      if (block_done_o) done_cyc_q.push_back(cyc);
      if (out_valid_o && out_ready_i) begin
        got_q.push_back(out_data_o);
        got_last_q.push_back(out_last_o);
        got_cyc_q.push_back(cyc);
        stalled = 1'b0;
      end else begin
        stalled = out_valid_o;
        held    = out_data_o;
      end
      @(posedge clk_i); #1; t++;
    end
    out_ready_i = 1'b1;
    if (got_q.size() < n) cap_timeout = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'hDEAD_BEEF; out_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    n_assert++;
    if ({in_ready_o, out_valid_o, out_last_o, ram_wr0_o, busy_o, block_done_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy=%b ov=%b last=%b wr=%b busy=%b done=%b want all 0",
               in_ready_o, out_valid_o, out_last_o, ram_wr0_o, busy_o, block_done_o);
    end
    n_assert++;
    if (out_data_o !== 32'h0 || ram_data0_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got out=%h wd=%h want 0", out_data_o, ram_data0_o);
    end
    n_assert++;
    if (ram_addr0_o !== 5'd0 || ram_addr1_o !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_addr: got a0=%0d a1=%0d want 0", ram_addr0_o, ram_addr1_o);
    end
    in_valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    n_assert++;
    if (in_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_rdy: got %b want 0", in_ready_o);
    end
    @(posedge clk_i); #1;
    n_assert++;
    if (in_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_rdy_rise: got %b want 1", in_ready_o);
    end
  endtask

  task automatic test_transpose_order();
    logic [31:0] g, e;
    bit gl;
    clear_sb();
    fork
      drive_words(32'h0, 32);
      capture(32, 1'b0, 300);
    join
    repeat (3) begin
      @(negedge clk_i);
      if (block_done_o) done_cyc_q.push_back(cyc);
    end
    n_assert++;
    if (drv_timeout || cap_timeout) begin
      n_fail++; $display("FAIL order_timeout: got drv=%b cap=%b want 0", drv_timeout, cap_timeout);
    end
    n_assert++;
    if (got_cyc_q.size() != 32 || acc_cyc_q.size() != 32) begin
      n_fail++; $display("FAIL order_count: got %0d outputs want 32", got_cyc_q.size());
    end else begin
      n_assert++;
      if (got_cyc_q[0] - acc_cyc_q[31] != 3) begin
        n_fail++;
        $display("FAIL order_latency: got %0d cycles after DRAIN entry want 2", got_cyc_q[0] - acc_cyc_q[31] - 1);
      end
      n_assert++;
      if (got_cyc_q[31] - got_cyc_q[0] != 31) begin
        n_fail++; $display("FAIL order_gapfree: got span %0d want 31", got_cyc_q[31] - got_cyc_q[0]);
      end
    end
    for (int k = 0; k < 32; k++) begin
      n_assert++;
      if (got_q.size() == 0 || exp_q.size() == 0) begin
        n_fail++; $display("FAIL order_word%0d: got no output want one", k);
      end else begin
        g = got_q.pop_front(); e = exp_q.pop_front(); gl = got_last_q.pop_front();
        if (g !== e || gl !== (k == 31)) begin
          n_fail++; $display("FAIL order_word%0d: got %h last=%b want %h last=%b", k, g, gl, e, k == 31);
        end
      end
    end
    n_assert++;
    if (done_cyc_q.size() != 1) begin
      n_fail++; $display("FAIL order_done_count: got %0d pulses want 1", done_cyc_q.size());
    end
    n_assert++;
    if (in_ready_o !== 1'b1 || busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL order_idle: got rdy=%b busy=%b ov=%b want 1 0 0", in_ready_o, busy_o, out_valid_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_backpressure();
    logic [31:0] g, e;
    bit gl;
    clear_sb();
    fork
      drive_words(32'h100, 32);
      capture(32, 1'b1, 2000);
    join
    repeat (3) begin
      @(negedge clk_i);
      if (block_done_o) done_cyc_q.push_back(cyc);
    end
    n_assert++;
    if (drv_timeout || cap_timeout) begin
      n_fail++; $display("FAIL bp_timeout: got drv=%b cap=%b want 0", drv_timeout, cap_timeout);
    end
    for (int k = 0; k < 32; k++) begin
      n_assert++;
      if (got_q.size() == 0 || exp_q.size() == 0) begin
        n_fail++; $display("FAIL bp_word%0d: got no output want one", k);
      end else begin
        g = got_q.pop_front(); e = exp_q.pop_front(); gl = got_last_q.pop_front();
        if (g !== e || gl !== (k == 31)) begin
          n_fail++; $display("FAIL bp_word%0d: got %h last=%b want %h last=%b", k, g, gl, e, k == 31);
        end
      end
    end
    n_assert++;
    if (stall_err != 0) begin
      n_fail++; $display("FAIL bp_stall_stable: got %0d changes want 0", stall_err);
    end
    n_assert++;
    if (occ_err != 0) begin
      n_fail++; $display("FAIL bp_occupancy: got %0d overflows want 0", occ_err);
    end
    n_assert++;
    if (done_cyc_q.size() != 1 || out_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL bp_done: got %0d pulses ov=%b want 1 pulse ov=0", done_cyc_q.size(), out_valid_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] g, e;
    clear_sb();
    fork
      drive_words(32'h200, 32);
      capture(10, 1'b0, 300);
    join
    for (int k = 0; k < 10; k++) begin
      n_assert++;
      if (got_q.size() == 0) begin
        n_fail++; $display("FAIL rstmid_pre%0d: got no output want one", k);
      end else begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        if (g !== e) begin
          n_fail++; $display("FAIL rstmid_pre%0d: got %h want %h", k, g, e);
        end
      end
    end
    rst_i = 1'b0;
    #1;
    n_assert++;
    if ({out_valid_o, out_last_o, in_ready_o, busy_o, ram_wr0_o} !== 5'b0 || out_data_o !== 32'h0
        || ram_addr1_o !== 5'd0) begin
      n_fail++;
      $display("FAIL rstmid_zero: got ov=%b last=%b rdy=%b busy=%b wr=%b out=%h a1=%0d want 0",
               out_valid_o, out_last_o, in_ready_o, busy_o, ram_wr0_o, out_data_o, ram_addr1_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    n_assert++;
    if (in_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_rdy: got %b want 1", in_ready_o);
    end
    clear_sb();
    fork
      drive_words(32'h300, 32);
      capture(32, 1'b0, 300);
    join
    for (int k = 0; k < 32; k++) begin
      n_assert++;
      if (got_q.size() == 0 || exp_q.size() == 0) begin
        n_fail++; $display("FAIL rstmid_post%0d: got no output want one", k);
      end else begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        if (g !== e) begin
          n_fail++; $display("FAIL rstmid_post%0d: got %h want %h", k, g, e);
        end
      end
    end
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] g, e;
    bit gl;
    clear_sb();
    fork
      drive_words(32'h400, 64);
      capture(64, 1'b0, 3000);
    join
    repeat (3) begin
      @(negedge clk_i);
      if (block_done_o) done_cyc_q.push_back(cyc);
    end
    n_assert++;
    if (drv_timeout || cap_timeout) begin
      n_fail++; $display("FAIL b2b_timeout: got drv=%b cap=%b want 0", drv_timeout, cap_timeout);
    end
    for (int k = 0; k < 64; k++) begin
      n_assert++;
      if (got_q.size() == 0 || exp_q.size() == 0) begin
        n_fail++; $display("FAIL b2b_word%0d: got no output want one", k);
      end else begin
        g = got_q.pop_front(); e = exp_q.pop_front(); gl = got_last_q.pop_front();
        if (g !== e || gl !== (k % 32 == 31)) begin
          n_fail++; $display("FAIL b2b_word%0d: got %h last=%b want %h last=%b", k, g, gl, e, k % 32 == 31);
        end
      end
    end
    n_assert++;
    if (done_cyc_q.size() != 2 || acc_cyc_q.size() != 64) begin
      n_fail++; $display("FAIL b2b_done_count: got %0d pulses %0d writes want 2 and 64",
                         done_cyc_q.size(), acc_cyc_q.size());
    end else begin
`ifdef JPEG_IDCT_TPOSE_OVERLAP_EN
      n_assert++;
      if (acc_cyc_q[32] < acc_cyc_q[31] + 2 || acc_cyc_q[32] >= done_cyc_q[0]) begin
        n_fail++; $display("FAIL b2b_overlap_write: got first write cycle %0d want in [%0d,%0d)",
                           acc_cyc_q[32], acc_cyc_q[31] + 2, done_cyc_q[0]);
      end
`else
      n_assert++;
      if (acc_cyc_q[32] <= done_cyc_q[0]) begin
        n_fail++; $display("FAIL b2b_drain_stall: got first write cycle %0d want after done cycle %0d",
                           acc_cyc_q[32], done_cyc_q[0]);
      end
`endif
    end
    n_assert++;
    if (busy_o !== 1'b0 || in_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL b2b_idle: got busy=%b rdy=%b want 0 1", busy_o, in_ready_o);
    end
  endtask

  initial begin
    rst_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b1;
    test_reset();
    test_transpose_order();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/jpeg_idct_transpose_ctrl.md
Name: jpeg_idct_transpose_ctrl

Overview:
Sequencer for the 32x32-bit IDCT transpose RAM between the row-pass and column-pass IDCT stages.
- Accepts one 8x8 block from the row pass as 32 words, written row-major. Each word holds two adjacent 16-bit columns.
- Drives the RAM write port with linear addresses, then drives the read port in column-pair-major (transposed) order.
- Streams the read data to the column pass through a 2-entry output buffer with valid/ready backpressure.

Parameters:
DATA_W, 32, RAM word width in bits.
ADDR_W, 5, RAM address width; BLOCK_WORDS = 2**ADDR_W = 32.

Ports:
clk_i  in  1  single clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
in_valid_i  in  1  row-pass word valid
in_data_i  in  DATA_W  row-pass word
in_ready_o  out  1  controller accepts word
out_valid_o  out  1  column-pass word valid
out_data_o  out  DATA_W  transposed word
out_last_o  out  1  marks 32nd word of block
out_ready_i  in  1  column pass accepts word
ram_wr0_o  out  1  RAM write enable
ram_addr0_o  out  ADDR_W  RAM write address
ram_data0_o  out  DATA_W  RAM write data
ram_addr1_o  out  ADDR_W  RAM read address; RAM returns data 1 cycle later
ram_data1_i  in  DATA_W  RAM registered read data
busy_o  out  1  state==DRAIN or output buffer non-empty
block_done_o  out  1  1-cycle pulse when last word accepted downstream

Behaviour:
- Reset (rst_i low, asynchronous) clears the following. All outputs are 0 while in reset; in_ready_o rises 1 cycle after reset release.
  - state=FILL
  - wr_cnt=0, rd_cnt=0
  - inflight=0, buffer empty
  - pending_full=0, read-done mask=0
- Reset mid-block discards the partial block entirely. RAM contents are not cleared.
- FILL:
  - in_ready_o=1.
  - On each in_valid_i & in_ready_o: ram_wr0_o=1 (combinational), ram_addr0_o=wr_cnt, ram_data0_o=in_data_i, wr_cnt++.
  - When the write with wr_cnt==31 is accepted: wr_cnt wraps to 0 and next state is DRAIN.
- DRAIN:
  - in_ready_o=0 (see Optional Feature).
  - Read issue rule: rd_cnt<32 and (occupancy + inflight − pop) < 2, where pop = out_valid_o & out_ready_i.
  - Issued read address: ram_addr1_o = {rd_cnt[2:0], rd_cnt[4:3]}, i.e. k -> (k%8)*4 + k/8.
  - Read sequence: 0, 4, 8, …, 28, 1, 5, …, 31.
  - ram_addr1_o holds its last value when no read is issued.
  - inflight is set the cycle a read is issued. The next cycle ram_data1_i is pushed into the buffer.
- Latency: read issued in cycle N; word enters the buffer at the end of N+1; out_valid_o is high in N+2.
  - Steady state with out_ready_i=1 sustains 1 word/cycle.
  - Entry to DRAIN -> first out_valid_o is 2 cycles.
- Output buffer: 2-entry FIFO.
  - out_data_o and out_last_o come from the head entry.
  - Overflow is impossible by construction of the issue rule.
  - out_last_o is tagged on the word read with rd_cnt==31.
- Block completion: pop of the word with out_last_o=1 pulses block_done_o; rd_cnt returns to 0.
  - If pending_full=1: stay in DRAIN and clear pending_full.
  - Otherwise: go to FILL.
- out_valid_o and the buffer contents hold while out_ready_i=0. Data must not change while valid and stalled.

Optional Feature:
JPEG_IDCT_TPOSE_OVERLAP_EN
- Defined:
  - A 32-bit read-done mask sets bit addr on each issued read and clears on block completion.
  - In DRAIN, in_ready_o = mask[wr_cnt] & ~pending_full. Writes of the next block proceed linearly into addresses already read.
  - mask is registered, so a same-cycle read/write of one address never occurs.
  - Accepting next-block word 31 sets pending_full.
  - Any writes not completed before drain ends continue in FILL.
- Undefined: the mask is absent, pending_full is tied 0, and writes are stalled for the whole DRAIN.

Decomposition:
- Package jpeg_idct_tpose_pkg holds:
  - BLOCK_WORDS and ADDR_W constants
  - state enum (FILL, DRAIN)
  - transposed-address function
- Sub-module jpeg_idct_tpose_buf: 2-entry valid/ready FIFO with a last tag and an occupancy output.

Test Plan:
- Write words 0x00000000..0x0000001F with out_ready_i=1 -> output order 0x00,0x04,…,0x1C,0x01,…,0x1F; out_last_o only on 0x1F; block_done_o pulses once; back in FILL.
- Gap-free stream -> first out_valid_o exactly 2 cycles after entering DRAIN; 32 outputs in 32 consecutive cycles.
- out_ready_i toggles 1/0 randomly -> no loss or duplication; out_data_o stable during stall; buffer never exceeds 2.
- Assert rst_i low at output word 10 -> outputs 0 immediately; after release in_ready_o=1; next block streams correctly.
- OVERLAP_EN: second block is presented during drain -> first next-block write occurs after address 0 is read, and never before the target address is read; both blocks come out transposed and correct.
- OVERLAP_EN off: in_valid_i held high during DRAIN -> in_ready_o=0 and ram_wr0_o=0 until block_done_o.
